clk_en_rst_gen: RTL and testbench
=================================

CLK_EN_RST_GEN -- requirements
Module: clk_en_rst_gen

Interface
REQ-001 SHALL have parameter LOCK_WAIT, default 1024: number of clk_sys cycles that lock must stay stable before the reset hold starts; legal range 1..65535.
REQ-002 SHALL have parameter RESET_HOLD, default 24: number of cycles core_reset stays high while the enables run; legal range 1..65535.
REQ-003 SHALL have port clk_sys, input, 1 bit: 36 MHz system clock, the only clock in the block.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to clk_sys.
REQ-006 SHALL have port pause, input, 1 bit: OSD pause request, synchronous to clk_sys.
REQ-007 SHALL have port core_reset, output, 1 bit: active-high reset to the game core.
REQ-008 SHALL have port ce_12m, output, 1 bit: 12 MHz clock enable, one clk_sys cycle wide.
REQ-009 SHALL have port ce_6m, output, 1 bit: 6 MHz clock enable, one clk_sys cycle wide.
REQ-010 SHALL have port ce_3m, output, 1 bit: 3 MHz clock enable, one clk_sys cycle wide.
REQ-011 SHALL have port ce_cpu, output, 1 bit: ce_3m gated by pause.
REQ-012 SHALL have port lock_lost, output, 1 bit: sticky flag, set when lock is lost while in RUN.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer to produce locked_s; no other logic SHALL use pll_locked directly.
REQ-014 SHALL implement a state machine with four states: WAIT_LOCK, STABLE, HOLD, RUN.
REQ-015 WAIT_LOCK: the stability counter SHALL clear; the machine SHALL move to STABLE on the first cycle locked_s=1.
REQ-016 STABLE: the counter SHALL increment each cycle.
- If locked_s=0, the machine SHALL return to WAIT_LOCK and clear the counter.
- Otherwise, when counter==LOCK_WAIT-1, it SHALL move to HOLD and clear the counter, so STABLE lasts exactly LOCK_WAIT cycles.
REQ-017 HOLD: the counter SHALL increment each cycle.
- If locked_s=0, the machine SHALL go to WAIT_LOCK.
- Otherwise, when counter==RESET_HOLD-1, it SHALL go to RUN, so HOLD lasts exactly RESET_HOLD cycles.
REQ-018 RUN: the machine SHALL stay in RUN while locked_s=1; when locked_s=0 it SHALL go to WAIT_LOCK and set lock_lost.
REQ-019 The counter SHALL be 16 bits wide and SHALL never wrap; its compare values SHALL bound it.
REQ-020 core_reset SHALL be 1 in every state except RUN.
REQ-021 Divider div SHALL be a mod-12 counter (0..11, with 11 wrapping to 0).
- It SHALL run only in HOLD and RUN.
- It SHALL be held at 0 in WAIT_LOCK and STABLE.
- It SHALL be 0 on the first HOLD cycle.
REQ-022 Enables SHALL be decoded only from registered state and div, with no combinational path from any input:
- ce_12m = run_en & (div in {0,3,6,9}).
- ce_6m = run_en & (div in {0,6}).
- ce_3m = run_en & (div==0).
- run_en = state in {HOLD, RUN}.
REQ-023 Consequently ce_12m SHALL pulse every 3 cycles, ce_6m every 6 and ce_3m every 12, and all three SHALL be coincident when div==0.
REQ-024 pause SHALL be registered once into pause_r.
- ce_cpu = ce_3m & ~(pause_r & state==RUN).
- pause SHALL have no effect in HOLD, so the CPU is clocked through its reset.
REQ-025 pause SHALL NOT stop div, ce_12m, ce_6m or ce_3m, so video and sound keep running.
REQ-026 lock_lost SHALL set only on a RUN->WAIT_LOCK transition; a lock drop in STABLE or HOLD SHALL NOT set it.
REQ-027 lock_lost SHALL clear only on rst_n=0.
REQ-028 Latency: after a pll_locked rise sampled at edge E0, state SHALL enter STABLE at E2, HOLD at E(2+LOCK_WAIT) and RUN at E(2+LOCK_WAIT+RESET_HOLD).
REQ-029 Latency: after a pll_locked fall sampled at E0, the machine SHALL be in WAIT_LOCK from E2, and enables MAY pulse during E0..E1 only.

Reset
REQ-030 On a clk_sys edge with rst_n=0:
- state SHALL go to WAIT_LOCK.
- The counter, div, both synchronizer flops, pause_r and lock_lost SHALL go to 0.
REQ-031 During and immediately after reset, outputs SHALL be: core_reset=1, ce_12m=ce_6m=ce_3m=ce_cpu=0, lock_lost=0.
REQ-032 rst_n=0 asserted in any state, including mid-HOLD or in RUN, SHALL take priority over all transitions, SHALL restart the full sequence, and SHALL NOT set lock_lost.

Verification (LOCK_WAIT=8, RESET_HOLD=24)
REQ-033 Power-up: rst_n released, then pll_locked=1 sampled at E0 -> core_reset=1 until E34; first coincident ce_12m/ce_6m/ce_3m at E10; core_reset=0 from E34; ce_3m period 12 thereafter.
REQ-034 Lock glitch: pll_locked high for 5 cycles, then low in STABLE -> return to WAIT_LOCK, no enables, lock_lost=0; a subsequent stable lock restarts the full 8-cycle wait.
REQ-035 Lock loss in RUN: drop pll_locked -> WAIT_LOCK at E2, core_reset=1, enables 0, lock_lost=1; relock -> RUN after 2+8+24 cycles with lock_lost still 1.
REQ-036 Pause: pause=1 in RUN -> ce_cpu=0 starting one cycle later; ce_12m/ce_6m/ce_3m unchanged; pause=1 during HOLD -> ce_cpu equals ce_3m.
REQ-037 Reset mid-operation: rst_n=0 for one cycle in RUN at div=5 -> next cycle core_reset=1, all enables 0, div=0, lock_lost=0; full sequence repeats (RUN after 34 cycles with pll_locked held 1).
REQ-038 Enable phasing: over 120 RUN cycles -> exactly 40 ce_12m, 20 ce_6m and 10 ce_3m pulses; every ce_3m coincides with a ce_6m and a ce_12m.

Source files
------------

// File: rtl/clk_en_rst_gen.sv
// Purpose : core reset sequencer and 12/6/3 MHz clock-enable generator from the 36 MHz clk_sys.
// Latency : pll_locked reaches the FSM after 2 synchronizer flops; enables decode registered state/div.
// Backpressure: none; pause gates only ce_cpu in RUN, and video/sound enables keep running.
//
// Ports:
//   clk_sys     in  36 MHz system clock, the only clock in the block
//   rst_n       in  synchronous active-low reset
//   pll_locked  in  PLL lock indication, asynchronous to clk_sys
//   pause       in  OSD pause request, synchronous to clk_sys
//   core_reset  out active-high game-core reset, low only in RUN
//   ce_12m      out 12 MHz enable, one clk_sys cycle wide
//   ce_6m       out 6 MHz enable, one clk_sys cycle wide
//   ce_3m       out 3 MHz enable, one clk_sys cycle wide
//   ce_cpu      out ce_3m gated by the registered pause, in RUN only
//   lock_lost   out sticky flag, set when lock drops while in RUN
module clk_en_rst_gen #(
    parameter int LOCK_WAIT  = 1024,
    parameter int RESET_HOLD = 24
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic pause,
    output logic core_reset,
    output logic ce_12m,
    output logic ce_6m,
    output logic ce_3m,
    output logic ce_cpu,
    output logic lock_lost
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Terminal counts. The counter is cleared on reaching these, so it
    // never climbs beyond 65534 and cannot wrap.
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_WAIT - 1);
    localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD - 1);
    localparam logic [3:0]  DIV_LAST  = 4'd11;

    logic        sync_ff1;
    logic        sync_ff2;
    logic        locked_s;
    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  div;
    logic [3:0]  div_next;
    logic        pause_r;
    logic        lock_lost_r;
    logic        run_en;

    assign locked_s = sync_ff2;
    assign div_next = (div == DIV_LAST) ? 4'd0 : div + 4'd1;

    // Two-flop synchronizer: the only consumer of pll_locked.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= pll_locked;
            sync_ff2 <= sync_ff1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            pause_r <= 1'b0;
        end else begin
            pause_r <= pause;
        end
    end

    // Sequencer. div is held at 0 until HOLD so the first HOLD cycle lands
    // on div==0, giving a coincident pulse of all three enables.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state       <= WAIT_LOCK;
            cnt         <= 16'd0;
            div         <= 4'd0;
            lock_lost_r <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cnt <= 16'd0;
                    div <= 4'd0;
                    if (locked_s) begin
                        state <= STABLE;
                    end
                end
                STABLE: begin
                    div <= 4'd0;
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= 16'd0;
                    end else if (cnt == LOCK_LAST) begin
                        state <= HOLD;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (!locked_s) begin
                        // Lock drop before RUN is a normal bring-up retry,
                        // not a lost lock.
                        state <= WAIT_LOCK;
                        cnt   <= 16'd0;
                        div   <= 4'd0;
                    end else begin
                        div <= div_next;
                        if (cnt == HOLD_LAST) begin
                            state <= RUN;
                            cnt   <= 16'd0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                RUN: begin
                    cnt <= 16'd0;
                    if (!locked_s) begin
                        state       <= WAIT_LOCK;
                        div         <= 4'd0;
                        lock_lost_r <= 1'b1;
                    end else begin
                        div <= div_next;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                    cnt   <= 16'd0;
                    div   <= 4'd0;
                end
            endcase
        end
    end

    // Output decode uses registered state/div only: no input reaches an
    // output combinationally.
    assign run_en     = (state == HOLD) || (state == RUN);
    assign ce_12m     = run_en && ((div == 4'd0) || (div == 4'd3) ||
                                   (div == 4'd6) || (div == 4'd9));
    assign ce_6m      = run_en && ((div == 4'd0) || (div == 4'd6));
    assign ce_3m      = run_en && (div == 4'd0);
    // Pause only bites in RUN so the CPU is still clocked through reset.
    assign ce_cpu     = ce_3m && !(pause_r && (state == RUN));
    assign core_reset = (state != RUN);
    assign lock_lost  = lock_lost_r;

endmodule

// File: tb/tb_clk_en_rst_gen.sv
module tb_clk_en_rst_gen;

    localparam int LW     = 8;
    localparam int RH     = 24;
    localparam int T_HOLD = 2 + LW;
    localparam int T_RUN  = 2 + LW + RH;

    logic clk_sys = 1'b0;
    logic rst_n;
    logic pll_locked;
    logic pause;
    logic core_reset;
    logic ce_12m;
    logic ce_6m;
    logic ce_3m;
    logic ce_cpu;
    logic lock_lost;

    always #5 clk_sys = ~clk_sys;

    clk_en_rst_gen #(
        .LOCK_WAIT (LW),
        .RESET_HOLD(RH)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .pause     (pause),
        .core_reset(core_reset),
        .ce_12m    (ce_12m),
        .ce_6m     (ce_6m),
        .ce_3m     (ce_3m),
        .ce_cpu    (ce_cpu),
        .lock_lost (lock_lost)
    );

    // Output vector order: {core_reset, ce_12m, ce_6m, ce_3m, ce_cpu, lock_lost}
    typedef struct {
        logic       rst_n;
        logic       pll;
        logic       pause;
        logic [5:0] exp;
    } vec_t;

    vec_t       vecs[6];
    logic [5:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         n12 = 0, n6 = 0, n3 = 0, n_bad_phase = 0;
    int         step_no = 0;
    bit         lost;

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs for after the
    // sampling edge, then pop and compare away from the edge.
    task automatic step(input logic r, input logic p, input logic pz,
                        input logic [5:0] e, input string name);
        logic [5:0] got;
        logic [5:0] want;
        rst_n      = r;
        pll_locked = p;
        pause      = pz;
        exp_q.push_back(e);
        @(posedge clk_sys);
        #1;
        got = {core_reset, ce_12m, ce_6m, ce_3m, ce_cpu, lock_lost};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s step=%0d scoreboard empty", name, step_no);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                failures++;
                $display("FAIL %s step=%0d got=%b want=%b (rst,12,6,3,cpu,lost)",
                         name, step_no, got, want);
            end
        end
        step_no++;
    endtask

    // Expected outputs k cycles after pll_locked=1 was first sampled, while
    // lock has been held throughout.
    function automatic logic [5:0] exp_normal(input int k, input logic pz, input logic lst);
        logic c12, c6, c3;
        int   d;
        c12 = 1'b0;
        c6  = 1'b0;
        c3  = 1'b0;
        if (k >= T_HOLD) begin
            d   = (k - T_HOLD) % 12;
            c12 = (d % 3) == 0;
            c6  = (d % 6) == 0;
            c3  = (d == 0);
        end
        return {(k < T_RUN), c12, c6, c3, c3 & ~(pz & (k >= T_RUN)), lst};
    endfunction

    // Lock for n_hi cycles then drop for n_lo cycles; optional reset at step rst_at.
    task automatic run_seg(input int n_hi, input int n_lo, input int rst_at,
                           input bit lost_in, input bit do_count, output bit lost_out);
        bit         lost_after;
        logic       pz;
        logic [5:0] e;
        lost_after = lost_in | ((n_hi + 1) >= T_RUN);
        lost_out   = lost_after;
        for (int k = 0; k < n_hi + n_lo; k++) begin
            pz = 1'($urandom_range(0, 1));
            if (k == rst_at) begin
                step(1'b0, 1'b1, pz, 6'b100000, "mid_reset");
                lost_out = 1'b0;
                return;
            end
            if (k < n_hi + 2)
                e = exp_normal(k, pz, lost_in);
            else
                e = {1'b1, 4'b0000, lost_after};
            step(1'b1, (k < n_hi), pz, e, "sequence");
            if (do_count && k >= T_RUN && k < T_RUN + 120) begin
                n12 += int'(ce_12m);
                n6  += int'(ce_6m);
                n3  += int'(ce_3m);
                if (ce_3m && !(ce_6m && ce_12m)) n_bad_phase++;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        pause      = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 6'b100000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 6'b100000};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 6'b100000};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 6'b100000};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 6'b100000};

        for (int i = 0; i < 6; i++)
            step(vecs[i].rst_n, vecs[i].pll, vecs[i].pause, vecs[i].exp, "reset_table");

        lost = 1'b0;
        // Glitch in STABLE: back to WAIT_LOCK, no enables, no lock_lost.
        run_seg(5, 4, -1, lost, 1'b0, lost);
        // Drop during HOLD: enables stop, still no lock_lost.
        run_seg(20, 4, -1, lost, 1'b0, lost);
        // Full power-up, 120+ RUN cycles, then loss of lock in RUN.
        run_seg(160, 4, -1, lost, 1'b1, lost);
        // Relock with lock_lost set, then reset in RUN when div==5.
        run_seg(60, 0, 40, lost, 1'b0, lost);
        // Full sequence again after mid-run reset, ending with another loss.
        run_seg(40, 4, -1, lost, 1'b0, lost);

        check_int("ce_12m_count", n12, 40);
        check_int("ce_6m_count", n6, 20);
        check_int("ce_3m_count", n3, 10);
        check_int("ce_phase_coincidence", n_bad_phase, 0);
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
